// File: rtl/matmul_pkg.sv
// Shared types and default sizing for the systolic matmul controller.
package matmul_pkg;

   localparam int unsigned MATMUL_DIM   = 4;
   localparam int unsigned MATMUL_K_MAX = 16;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      WRITE,
      DONE
   } matmul_ctrl_state_t;

endpackage

// File: rtl/matmul_ctrl_if.sv
// Control/handshake bundle between the matmul sequencer and the host/datapath side.
// The master modport is the sequencer; the slave modport is the host/datapath side.
interface matmul_intf import matmul_pkg::*; #(
   parameter int unsigned DIM   = MATMUL_DIM,
   parameter int unsigned K_MAX = MATMUL_K_MAX
);

   localparam int unsigned KW = $clog2(K_MAX + 1);
   localparam int unsigned AW = $clog2(K_MAX);
   localparam int unsigned RW = $clog2(DIM);

   logic          start_i;
   logic [KW-1:0] k_i;
   logic          abort_i;
   logic          busy_o;
   logic          done_o;
   logic          pe_clear_o;
   logic          op_rd_en_o;
   logic [AW-1:0] op_rd_addr_o;
   logic          pe_en_o;
   logic          op_zero_o;
   logic          res_wr_en_o;
   logic [RW-1:0] res_row_o;
   logic          res_ready_i;

   modport master (
      input  start_i, k_i, abort_i, res_ready_i,
      output busy_o, done_o, pe_clear_o, op_rd_en_o, op_rd_addr_o,
             pe_en_o, op_zero_o, res_wr_en_o, res_row_o
   );

   modport slave (
      output start_i, k_i, abort_i, res_ready_i,
      input  busy_o, done_o, pe_clear_o, op_rd_en_o, op_rd_addr_o,
             pe_en_o, op_zero_o, res_wr_en_o, res_row_o
   );

endinterface

// File: rtl/matmul_ctrl.sv
// Sequencer for the DIM x DIM systolic matmul array: clear, feed K operands,
// drain the skew, then write DIM result rows under backpressure.
// Optional feature: define MATMUL_CTRL_PERF_EN to add the perf_cycles_o busy-cycle counter.
module matmul_ctrl import matmul_pkg::*; #(
   parameter int unsigned DIM   = MATMUL_DIM,
   parameter int unsigned K_MAX = MATMUL_K_MAX
) (
   input  logic        clk_i,
   input  logic        rst_ni,
`ifdef MATMUL_CTRL_PERF_EN
   output logic [31:0] perf_cycles_o,
`endif
   matmul_intf.master  bus
);

   localparam int unsigned KW = $clog2(K_MAX + 1);
   localparam int unsigned AW = $clog2(K_MAX);
   localparam int unsigned RW = $clog2(DIM);
   localparam int unsigned DW = $clog2(2 * DIM);

   localparam logic [KW-1:0] K_SAT      = KW'(K_MAX);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * DIM - 2);
   localparam logic [RW-1:0] ROW_LAST   = RW'(DIM - 1);

   matmul_ctrl_state_t state_q, state_d;

   logic [KW-1:0] k_q;
   logic [AW-1:0] kcnt_q;
   logic [DW-1:0] dcnt_q;
   logic [RW-1:0] row_q;

   logic start_acc;
   logic feed_last;
   logic drain_last;

   assign start_acc  = (state_q == IDLE) && bus.start_i && (bus.k_i != '0) && !bus.abort_i;
   assign feed_last  = (KW'(kcnt_q) == (k_q - KW'(1)));
   assign drain_last = (dcnt_q == DRAIN_LAST);

   // Next-state decode; abort from any active state wins over everything else.
   always_comb begin
      state_d = state_q;
      if (state_q != IDLE && bus.abort_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start_acc) state_d = CLEAR;
            CLEAR:   state_d = FEED;
            FEED:    if (feed_last) state_d = DRAIN;
            DRAIN:   if (drain_last) state_d = WRITE;
            WRITE:   if (bus.res_ready_i && row_q == ROW_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Phase counters run only while staying in their own phase, so any exit (including abort) zeroes them.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         k_q    <= '0;
         kcnt_q <= '0;
         dcnt_q <= '0;
         row_q  <= '0;
      end else begin
         if (start_acc) k_q <= (bus.k_i > K_SAT) ? K_SAT : bus.k_i;
         kcnt_q <= (state_q == FEED  && state_d == FEED)  ? kcnt_q + AW'(1) : '0;
         dcnt_q <= (state_q == DRAIN && state_d == DRAIN) ? dcnt_q + DW'(1) : '0;
         if (state_q == WRITE && state_d == WRITE) begin
            if (bus.res_ready_i) row_q <= row_q + RW'(1);
         end else begin
            row_q <= '0;
         end
      end
   end

   // pe_en covers the cycle after every read (FEED cycles 2..K) plus all of DRAIN.
   assign bus.busy_o       = (state_q != IDLE);
   assign bus.done_o       = (state_q == DONE);
   assign bus.pe_clear_o   = (state_q == CLEAR);
   assign bus.op_rd_en_o   = (state_q == FEED);
   assign bus.op_rd_addr_o = kcnt_q;
   assign bus.pe_en_o      = (state_q == FEED && kcnt_q != '0) || (state_q == DRAIN);
   assign bus.op_zero_o    = (state_q == DRAIN && dcnt_q != '0);
   assign bus.res_wr_en_o  = (state_q == WRITE);
   assign bus.res_row_o    = row_q;

`ifdef MATMUL_CTRL_PERF_EN
   logic [31:0] perf_q;

   // Busy-cycle counter: cleared on accepted start, saturating, held while idle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                           perf_q <= '0;
      else if (start_acc)                    perf_q <= '0;
      else if (state_q != IDLE && perf_q != '1) perf_q <= perf_q + 32'd1;
   end

   assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// Scoreboard bench for matmul_ctrl: the reference model turns each accepted start
// into per-strobe event lists (cycle, value); a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_matmul_ctrl;

   localparam int DIM   = 4;
   localparam int K_MAX = 16;

   localparam int EK_CLR  = 0;
   localparam int EK_RD   = 1;
   localparam int EK_PEN  = 2;
   localparam int EK_ZERO = 3;
   localparam int EK_WR   = 4;
   localparam int EK_DONE = 5;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   matmul_intf #(.DIM(DIM), .K_MAX(K_MAX)) bus ();

`ifdef MATMUL_CTRL_PERF_EN
   logic [31:0] perf;
`endif

   matmul_ctrl #(.DIM(DIM), .K_MAX(K_MAX)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
`ifdef MATMUL_CTRL_PERF_EN
      .perf_cycles_o (perf),
`endif
      .bus           (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int  checks = 0;
   int  failures = 0;
   ev_t evq [6][$];
   int  ready_mode = 0;
   int  stall_lo = -1;
   int  stall_hi = -1;
   int  last_wr_cyc = -1;
   int  last_done_cyc = -1;
   int  done_cnt = 0;

   function automatic void check(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void expect_ev(int kind, string name, int val);
      ev_t e;
      checks++;
      if (evq[kind].size() == 0) begin
         failures++;
         $display("FAIL %s_unexpected: got event val %0d at cycle %0d, expected none", name, val, cyc);
         return;
      end
      e = evq[kind].pop_front();
      if (e.val != val || e.cyc != cyc) begin
         failures++;
         $display("FAIL %s: got val %0d at cycle %0d, expected val %0d at cycle %0d",
                  name, val, cyc, e.val, e.cyc);
      end
   endfunction

   function automatic bit ready_at(int c);
      if (ready_mode == 0) return 1'b1;
      return !(c >= stall_lo && c <= stall_hi);
   endfunction

   function automatic void push(int kind, int c, int v, int abort_cyc);
      ev_t e;
      e.cyc = c;
      e.val = v;
      if (abort_cyc < 0 || c <= abort_cyc) evq[kind].push_back(e);
   endfunction

   // Reference model: timeline of one run started (accepted) at cycle t.
   function automatic void model_run(int t, int k_raw, int abort_cyc);
      int k;
      int w;
      int c;
      ev_t e;
      k = (k_raw > K_MAX) ? K_MAX : k_raw;
      w = t + k + 2 * DIM + 1;
      push(EK_CLR, t + 1, 0, abort_cyc);
      for (int a = 0; a < k; a++) push(EK_RD, t + 2 + a, a, abort_cyc);
      for (int c2 = t + 3; c2 <= t + k + 2 * DIM; c2++) push(EK_PEN, c2, 0, abort_cyc);
      for (int c2 = t + k + 3; c2 <= t + k + 2 * DIM; c2++) push(EK_ZERO, c2, 0, abort_cyc);
      if (abort_cyc >= 0) return;
      if (ready_mode == 2) begin
         stall_lo = w + 2;
         stall_hi = w + 4;
      end
      if (ready_mode == 1) begin
         for (int r = 0; r < DIM; r++) begin
            e.cyc = -1;
            e.val = r;
            evq[EK_WR].push_back(e);
         end
         e.cyc = -1;
         e.val = 0;
         evq[EK_DONE].push_back(e);
      end else begin
         c = w;
         for (int r = 0; r < DIM; r++) begin
            while (!ready_at(c)) c++;
            push(EK_WR, c, r, -1);
            c++;
         end
         push(EK_DONE, c, 0, -1);
      end
   endfunction

   // Monitor: pops expected events whenever the DUT shows the matching strobe.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.pe_clear_o) expect_ev(EK_CLR, "pe_clear", 0);
            if (bus.op_rd_en_o) expect_ev(EK_RD, "op_rd_addr", int'(bus.op_rd_addr_o));
            if (bus.pe_en_o)    expect_ev(EK_PEN, "pe_en", 0);
            if (bus.op_zero_o)  expect_ev(EK_ZERO, "op_zero", 0);
            if (bus.res_wr_en_o && bus.res_ready_i) begin
               if (evq[EK_WR].size() > 0 && evq[EK_WR][0].cyc < 0) evq[EK_WR][0].cyc = cyc;
               expect_ev(EK_WR, "res_row", int'(bus.res_row_o));
               last_wr_cyc = cyc;
            end
            if (bus.done_o) begin
               if (evq[EK_DONE].size() > 0 && evq[EK_DONE][0].cyc < 0)
                  evq[EK_DONE][0].cyc = last_wr_cyc + 1;
               expect_ev(EK_DONE, "done", 0);
               done_cnt++;
               last_done_cyc = cyc;
            end
         end
      end
   end

   // Result sink readiness driver.
   initial begin
      bus.res_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.res_ready_i = 1'b1;
            1:       bus.res_ready_i = 1'($urandom_range(0, 1));
            default: bus.res_ready_i = ready_at(cyc);
         endcase
      end
   end

   task automatic do_start(input int k, input int ab_off, output int t);
      @(posedge clk);
      #1;
      bus.start_i = 1'b1;
      bus.k_i     = 5'(k);
      t = cyc;
      if (k != 0) model_run(t, k, (ab_off >= 0) ? t + ab_off : -1);
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
   endtask

   task automatic check_empty(input string name);
      check({name, "_left_clr"},  evq[EK_CLR].size(), 0);
      check({name, "_left_rd"},   evq[EK_RD].size(), 0);
      check({name, "_left_pen"},  evq[EK_PEN].size(), 0);
      check({name, "_left_zero"}, evq[EK_ZERO].size(), 0);
      check({name, "_left_wr"},   evq[EK_WR].size(), 0);
      check({name, "_left_done"}, evq[EK_DONE].size(), 0);
   endtask

   task automatic wait_done(input int t, input string name);
      int n0;
      int b;
      n0 = done_cnt;
      b = 0;
      while (done_cnt == n0 && b < 300) begin
         @(negedge clk);
         b++;
      end
      check({name, "_done_count"}, done_cnt - n0, 1);
      @(negedge clk);
      @(negedge clk);
      check({name, "_busy_after"}, bus.busy_o, 0);
`ifdef MATMUL_CTRL_PERF_EN
      check({name, "_perf"}, perf, last_done_cyc - t);
`endif
      check_empty(name);
   endtask

   function automatic logic [15:0] out_vec();
      return {bus.busy_o, bus.done_o, bus.pe_clear_o, bus.op_rd_en_o, bus.op_rd_addr_o,
              bus.pe_en_o, bus.op_zero_o, bus.res_wr_en_o, bus.res_row_o, 3'b000};
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int k;
      bus.start_i = 1'b0;
      bus.k_i     = '0;
      bus.abort_i = 1'b0;
      #1;
      check("reset_outputs", out_vec(), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Nominal K=3.
      ready_mode = 0;
      do_start(3, -1, t);
      wait_done(t, "nominal");
`ifdef MATMUL_CTRL_PERF_EN
      check("nominal_perf16", perf, 16);
`endif

      // Backpressure on row 2 for 3 cycles.
      ready_mode = 2;
      do_start(3, -1, t);
      wait_done(t, "backpressure");
      check("backpressure_done_cyc", last_done_cyc, t + 19);
      ready_mode = 0;

      // Saturation of K.
      do_start(20, -1, t);
      wait_done(t, "saturate");

      // k=0 is ignored.
      do_start(0, -1, t);
      @(negedge clk);
      check("k0_busy", bus.busy_o, 0);
      check_empty("k0");

      // Start pulse during DRAIN is ignored.
      do_start(6, -1, t);
      while (cyc < t + 10) begin
         @(posedge clk);
         #1;
      end
      bus.start_i = 1'b1;
      bus.k_i     = 5'd5;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      wait_done(t, "busy_start");
      repeat (30) @(negedge clk);
      check("busy_start_no_extra", bus.busy_o, 0);
      check_empty("busy_start_tail");

      // Abort in FEED at addr 5.
      do_start(10, 7, t);
      while (cyc < t + 7) begin
         @(posedge clk);
         #1;
      end
      bus.abort_i = 1'b1;
      @(posedge clk);
      #1;
      bus.abort_i = 1'b0;
      @(negedge clk);
      check("abort_outputs", out_vec(), 0);
      repeat (20) @(negedge clk);
      check("abort_busy", bus.busy_o, 0);
      check_empty("abort");
      do_start(3, -1, t);
      wait_done(t, "post_abort");

      // Asynchronous reset mid-WRITE.
      do_start(3, -1, t);
      while (cyc < t + 13) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_outputs", out_vec(), 0);
`ifdef MATMUL_CTRL_PERF_EN
      check("midreset_perf", perf, 0);
`endif
      foreach (evq[i]) evq[i].delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      do_start(3, -1, t);
      wait_done(t, "post_reset");

      // Randomized runs.
      for (int i = 0; i < 10; i++) begin
         k = int'($urandom_range(0, 20));
         ready_mode = int'($urandom_range(0, 2));
         do_start(k, -1, t);
         if (k == 0) begin
            @(negedge clk);
            check("rand_k0_busy", bus.busy_o, 0);
         end else begin
            wait_done(t, "random");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
